// File: rtl/div_bfloat16_seq.sv
// Sequential bfloat16 divider: restoring radix-2 significand division, one quotient
// bit per clock, fixed latency for every operand class, valid/ready on both sides.
module div_bfloat16_seq #(
  parameter int N_SIG  = 7,
  parameter int N_EXP  = 8,
  parameter int N_DATA = N_EXP + N_SIG + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_DATA-1:0] a,
  input  logic [N_DATA-1:0] b,
  input  logic [2:0]        rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_DATA-1:0] o,
  output logic [7:0]        status
);

  localparam int BIAS = 2 ** (N_EXP - 1) - 1;
  localparam int MW   = N_SIG + 1;
  localparam int QW   = N_SIG + 2;
  localparam int RW   = N_SIG + 3;
  localparam int EW   = N_EXP + 2;
  localparam int CW   = $clog2(N_SIG + 2);
  localparam logic [CW-1:0]        CNT_LAST = CW'(N_SIG + 1);
  localparam logic signed [EW-1:0] EMAX     = EW'(2 ** N_EXP - 1);
  localparam logic [N_EXP-1:0]     EXP_ONES = '1;
  localparam int S_ZERO = 0, S_INF = 1, S_INV = 2, S_TINY = 3;
  localparam int S_HUGE = 4, S_INEX = 5, S_DIVZ = 7;

  typedef enum logic [2:0] {IDLE, UNPACK, ITER, ROUND, DONE} state_t;

  state_t state_r, state_nxt;

  logic [N_DATA-1:0]     a_r, b_r;
  logic [2:0]            rnd_r;
  logic                  sign_r;
  logic signed [EW-1:0]  exp_r;
  logic [MW-1:0]         mb_r;
  logic [RW-1:0]         rem_r;
  logic [QW-1:0]         q_r;
  logic [CW-1:0]         cnt_r;
  logic                  cls_nan, cls_divz, cls_inf, cls_zero;
  logic [N_DATA-1:0]     o_r;
  logic [7:0]            status_r;

  logic [N_EXP-1:0]      ea, eb;
  logic [N_SIG-1:0]      fa, fb;
  logic [MW-1:0]         ma, mb;
  logic                  adj;
  logic [RW-1:0]         rem0;
  logic signed [EW-1:0]  e0;
  logic                  a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  logic                  ge;
  logic [RW-1:0]         diff;

  logic                  guard, sticky, lsb, round_up, carry;
  logic [QW-1:0]         sum;
  logic [N_SIG-1:0]      mant;
  logic signed [EW-1:0]  e_fin;
  logic [N_DATA-1:0]     o_nxt;
  logic [7:0]            status_nxt;

  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (in_valid) state_nxt = UNPACK;
      UNPACK:  state_nxt = ITER;
      ITER:    if (cnt_r == CNT_LAST) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_r == IDLE) && !rst;
    out_valid = (state_r == DONE);
  end

  // Operand decode; a zero exponent field flushes the operand to zero.
  always_comb begin
    ea     = a_r[N_DATA-2 -: N_EXP];
    eb     = b_r[N_DATA-2 -: N_EXP];
    fa     = a_r[N_SIG-1:0];
    fb     = b_r[N_SIG-1:0];
    ma     = (ea == '0) ? '0 : {1'b1, fa};
    mb     = (eb == '0) ? '0 : {1'b1, fb};
    adj    = (ma < mb);
    rem0   = adj ? {1'b0, ma, 1'b0} : {2'b00, ma};
    e0     = EW'(ea) - EW'(eb) + EW'(BIAS) - EW'(adj);
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
  end

  always_comb begin
    ge   = (rem_r >= {2'b00, mb_r});
    diff = ge ? (rem_r - {2'b00, mb_r}) : rem_r;
  end

  // Rounding and final classification, highest-priority special case first.
  always_comb begin
    guard = q_r[0];
    lsb   = q_r[1];
    sticky = (rem_r != '0);
    case (rnd_r)
      3'd1:    round_up = 1'b0;
      3'd2:    round_up = !sign_r && (guard || sticky);
      3'd3:    round_up = sign_r && (guard || sticky);
      3'd4:    round_up = guard;
      default: round_up = guard && (sticky || lsb);
    endcase
    sum   = {1'b0, q_r[QW-1:1]} + QW'(round_up);
    carry = sum[QW-1];
    mant  = carry ? sum[N_SIG:1] : sum[N_SIG-1:0];
    e_fin = exp_r + EW'(carry);

    o_nxt              = {sign_r, e_fin[N_EXP-1:0], mant};
    status_nxt         = '0;
    status_nxt[S_INEX] = guard || sticky;
    if (cls_nan) begin
      o_nxt             = {1'b0, EXP_ONES, 1'b1, {(N_SIG-1){1'b0}}};
      status_nxt        = '0;
      status_nxt[S_INV] = 1'b1;
    end else if (cls_divz) begin
      o_nxt              = {sign_r, EXP_ONES, {N_SIG{1'b0}}};
      status_nxt         = '0;
      status_nxt[S_INF]  = 1'b1;
      status_nxt[S_DIVZ] = 1'b1;
    end else if (cls_inf) begin
      o_nxt             = {sign_r, EXP_ONES, {N_SIG{1'b0}}};
      status_nxt        = '0;
      status_nxt[S_INF] = 1'b1;
    end else if (cls_zero) begin
      o_nxt              = {sign_r, {(N_DATA-1){1'b0}}};
      status_nxt         = '0;
      status_nxt[S_ZERO] = 1'b1;
    end else if (e_fin >= EMAX) begin
      status_nxt         = '0;
      status_nxt[S_HUGE] = 1'b1;
      status_nxt[S_INEX] = 1'b1;
      if ((rnd_r == 3'd1) || (rnd_r == 3'd2 && sign_r) || (rnd_r == 3'd3 && !sign_r)) begin
        o_nxt = {sign_r, EXP_ONES - 1'b1, {N_SIG{1'b1}}};
      end else begin
        o_nxt             = {sign_r, EXP_ONES, {N_SIG{1'b0}}};
        status_nxt[S_INF] = 1'b1;
      end
    end else if (e_fin <= 0) begin
      o_nxt              = {sign_r, {(N_DATA-1){1'b0}}};
      status_nxt         = '0;
      status_nxt[S_ZERO] = 1'b1;
      status_nxt[S_TINY] = 1'b1;
      status_nxt[S_INEX] = 1'b1;
    end
  end

  // The iteration runs for special cases too, so latency never depends on the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r      <= '0;
      status_r <= '0;
    end else begin
      case (state_r)
        IDLE: if (in_valid) begin
          a_r   <= a;
          b_r   <= b;
          rnd_r <= rnd;
        end
        UNPACK: begin
          sign_r   <= a_r[N_DATA-1] ^ b_r[N_DATA-1];
          exp_r    <= e0;
          mb_r     <= mb;
          rem_r    <= rem0;
          q_r      <= '0;
          cnt_r    <= '0;
          cls_nan  <= a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf);
          cls_divz <= b_zero && !a_inf;
          cls_inf  <= a_inf;
          cls_zero <= a_zero || b_inf;
        end
        ITER: begin
          rem_r <= diff << 1;
          q_r   <= {q_r[QW-2:0], ge};
          cnt_r <= cnt_r + 1'b1;
        end
        ROUND: begin
          o_r      <= o_nxt;
          status_r <= status_nxt;
        end
        default: ;
      endcase
    end
  end

  assign o      = o_r;
  assign status = status_r;

endmodule

// File: tb/tb_div_bfloat16_seq.sv
// Directed bench for div_bfloat16_seq: hand-computed quotients, flags, latency,
// backpressure and mid-operation reset.
module tb_div_bfloat16_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  rnd = '0;
  logic        in_ready, out_valid;
  logic [15:0] o;
  logic [7:0]  status;

  int vectors = 0;
  int miscompares = 0;

  div_bfloat16_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .status(status)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Accept one operation and count edges until out_valid (bounded); rnd and
  // operands are scrambled right after the accept edge.
  task automatic startOp(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vr,
                         output int lat);
    int waitCnt;
    @(negedge clk);
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("in_ready before accept", 32'(in_ready), 32'd1);
    a = va; b = vb; rnd = vr; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rnd = vr ^ 3'd1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb, input logic [2:0] vr,
                               input logic [15:0] eo, input logic [7:0] es);
    int lat;
    string tag;
    tag = $sformatf("%04h/%04h r%0d", va, vb, vr);
    startOp(va, vb, vr, lat);
    checkOutput({tag, " latency"}, 32'(lat), 32'd11);
    checkOutput({tag, " o"}, 32'(o), 32'(eo));
    checkOutput({tag, " status"}, 32'(status), 32'(es));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] heldO;
    logic [7:0]  heldS;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset o", 32'(o), 32'd0);
    checkOutput("reset status", 32'(status), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    applyStimulus(16'h3F80, 16'h4000, 3'd0, 16'h3F00, 8'h00);
    applyStimulus(16'h4040, 16'h3F80, 3'd0, 16'h4040, 8'h00);
    applyStimulus(16'h3F80, 16'h4040, 3'd0, 16'h3EAB, 8'h20);
    applyStimulus(16'h3F80, 16'h4040, 3'd1, 16'h3EAA, 8'h20);
    applyStimulus(16'h3F80, 16'h4040, 3'd3, 16'h3EAA, 8'h20);
    applyStimulus(16'h3F80, 16'h4040, 3'd2, 16'h3EAB, 8'h20);
    applyStimulus(16'h3F80, 16'h4040, 3'd4, 16'h3EAB, 8'h20);
    applyStimulus(16'h3F80, 16'h4040, 3'd7, 16'h3EAB, 8'h20);
    applyStimulus(16'hBF80, 16'h4040, 3'd2, 16'hBEAA, 8'h20);
    applyStimulus(16'hBF80, 16'h4040, 3'd3, 16'hBEAB, 8'h20);
    applyStimulus(16'h3F80, 16'h3F81, 3'd2, 16'h3F7F, 8'h20);
    applyStimulus(16'h3F80, 16'h3F81, 3'd0, 16'h3F7E, 8'h20);

    applyStimulus(16'h3F80, 16'h0000, 3'd0, 16'h7F80, 8'h82);
    applyStimulus(16'h0000, 16'h0000, 3'd0, 16'h7FC0, 8'h04);
    applyStimulus(16'hBF80, 16'h7F80, 3'd0, 16'h8000, 8'h01);
    applyStimulus(16'h7FC1, 16'h3F80, 3'd0, 16'h7FC0, 8'h04);
    applyStimulus(16'h7F80, 16'h0000, 3'd0, 16'h7F80, 8'h02);
    applyStimulus(16'h7F80, 16'h7F80, 3'd0, 16'h7FC0, 8'h04);

    applyStimulus(16'h7F00, 16'h0080, 3'd0, 16'h7F80, 8'h32);
    applyStimulus(16'h7F00, 16'h0080, 3'd1, 16'h7F7F, 8'h30);
    applyStimulus(16'h7F00, 16'h0080, 3'd2, 16'h7F80, 8'h32);
    applyStimulus(16'h7F00, 16'h0080, 3'd3, 16'h7F7F, 8'h30);
    applyStimulus(16'hFF00, 16'h0080, 3'd2, 16'hFF7F, 8'h30);
    applyStimulus(16'hFF00, 16'h0080, 3'd3, 16'hFF80, 8'h32);
    applyStimulus(16'h0080, 16'h4000, 3'd0, 16'h0000, 8'h29);
    applyStimulus(16'h8080, 16'h4000, 3'd0, 16'h8000, 8'h29);

    // Backpressure: result must stay put and busy-state in_valid pulses are ignored.
    startOp(16'h3F80, 16'h4040, 3'd0, lat);
    checkOutput("hold latency", 32'(lat), 32'd11);
    checkOutput("hold o", 32'(o), 32'h3EAB);
    heldO = o;
    heldS = status;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 16'h4000; b = 16'h3F80; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("hold o stable", 32'(o), 32'(heldO));
      checkOutput("hold status stable", 32'(status), 32'h20);
      checkOutput("hold out_valid", 32'(out_valid), 32'd1);
      checkOutput("hold in_ready", 32'(in_ready), 32'd0);
    end
    checkOutput("hold status latched", 32'(heldS), 32'h20);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release out_valid", 32'(out_valid), 32'd0);
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h4000, 16'h3F80, 3'd0, 16'h4000, 8'h00);

    // Reset during the iteration phase discards the operation.
    @(negedge clk);
    a = 16'h3F80; b = 16'h4040; rnd = 3'd0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset o", 32'(o), 32'd0);
    checkOutput("mid reset status", 32'(status), 32'd0);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
    applyStimulus(16'h4000, 16'h3F80, 3'd0, 16'h4000, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
